rcnt_seq: RTL

Sequencer for the `rcnt` 256×32 shift/rotate register. Accepts a job command, streams `load_len` words from a valid/ready source into `rcnt` in shift-load mode (`mode=0`), then issues `rot_len` rotate-by-2 steps (`mode=1`), then pulses `done`. Sits directly in front of `rcnt` and drives its `x`, `shift` and `mode` inputs; it is the only master of those pins.

---
 rtl/rcnt_pkg.sv | 24 ++
 rtl/rcnt_seq_if.sv | 45 ++++
 rtl/rcnt_seq_cnt.sv | 41 ++++
 rtl/rcnt_seq.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/rcnt_pkg.sv
// ============================================================================
// Module      : rcnt_pkg
// Description : Shared types and constants for the rcnt sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rcnt_pkg;

    localparam int RCNT_DW    = 32;
    localparam int RCNT_DEPTH = 256;
    localparam int RCNT_LEN_W = 9;
    localparam int RCNT_ROT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ROTATE = 2'd2,
        ST_DONE   = 2'd3
    } rcnt_seq_state_t;

endpackage

`default_nettype wire

// File: rtl/rcnt_seq_if.sv
// ============================================================================
// Module      : rcnt_seq_if
// Description : Job command, source stream and rcnt drive bundle.
//               Optional abort signal with RCNT_SEQ_ABORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rcnt_seq_if #(
    parameter int DW = 32
);
    logic          start;
    logic [8:0]    load_len;
    logic [7:0]    rot_len;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [DW-1:0] rc_x;
    logic          rc_shift;
    logic          rc_mode;
    logic          busy;
    logic          done;
`ifdef RCNT_SEQ_ABORT_EN
    logic          abort;
`endif

    modport slave (
        input  start, load_len, rot_len, in_valid, in_data,
`ifdef RCNT_SEQ_ABORT_EN
        input  abort,
`endif
        output in_ready, rc_x, rc_shift, rc_mode, busy, done
    );

    modport master (
        output start, load_len, rot_len, in_valid, in_data,
`ifdef RCNT_SEQ_ABORT_EN
        output abort,
`endif
        input  in_ready, rc_x, rc_shift, rc_mode, busy, done
    );

endinterface

`default_nettype wire

// File: rtl/rcnt_seq_cnt.sv
// ============================================================================
// Module      : rcnt_seq_cnt
// Description : Loadable saturating down-counter with last (value==1) flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rcnt_seq_cnt #(
    parameter int W = 9
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         i_clr,
    input  wire logic         i_load,
    input  wire logic [W-1:0] i_load_val,
    input  wire logic         i_dec,
    output logic      [W-1:0] o_value,
    output logic              o_last
);

    logic [W-1:0] r_value;

    // Clear beats load beats decrement; decrement stops at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_value <= '0;
        end else if (i_clr) begin
            r_value <= '0;
        end else if (i_load) begin
            r_value <= i_load_val;
        end else if (i_dec && (r_value != '0)) begin
            r_value <= r_value - W'(1);
        end
    end

    assign o_value = r_value;
    assign o_last  = (r_value == W'(1));

endmodule

`default_nettype wire

// File: rtl/rcnt_seq.sv
// ============================================================================
// Module      : rcnt_seq
// Description : Load/rotate job sequencer driving the rcnt shift register.
//               RCNT_SEQ_ABORT_EN adds an abort input on the interface.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rcnt_seq
    import rcnt_pkg::*;
#(
    parameter int DW    = RCNT_DW,
    parameter int DEPTH = RCNT_DEPTH
) (
    input wire logic   clk,
    input wire logic   reset,
    rcnt_seq_if.slave  bus
);

    rcnt_seq_state_t          r_state;
    rcnt_seq_state_t          w_state_nxt;

    logic [RCNT_LEN_W-1:0]    w_load_sat;
    logic [RCNT_LEN_W-1:0]    w_ld_value;
    logic                     w_ld_last;
    logic [RCNT_ROT_W-1:0]    w_rot_value;
    logic                     w_rot_last;

    logic                     w_abort;
    logic                     w_cnt_load;
    logic                     w_cnt_clr;
    logic                     w_ld_dec;
    logic                     w_rot_dec;
    logic                     w_in_ready;
    logic                     w_shift;
    logic                     w_mode;
    logic                     w_done;
    logic [DW-1:0]            w_x;

    assign w_load_sat = (bus.load_len > RCNT_LEN_W'(DEPTH)) ? RCNT_LEN_W'(DEPTH) : bus.load_len;

`ifdef RCNT_SEQ_ABORT_EN
    assign w_abort = bus.abort && (r_state != ST_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    rcnt_seq_cnt #(.W(RCNT_LEN_W)) u_load_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (w_cnt_clr),
        .i_load     (w_cnt_load),
        .i_load_val (w_load_sat),
        .i_dec      (w_ld_dec),
        .o_value    (w_ld_value),
        .o_last     (w_ld_last)
    );

    rcnt_seq_cnt #(.W(RCNT_ROT_W)) u_rot_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (w_cnt_clr),
        .i_load     (w_cnt_load),
        .i_load_val (bus.rot_len),
        .i_dec      (w_rot_dec),
        .o_value    (w_rot_value),
        .o_last     (w_rot_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_load  = 1'b0;
        w_cnt_clr   = 1'b0;
        w_ld_dec    = 1'b0;
        w_rot_dec   = 1'b0;
        w_in_ready  = 1'b0;
        w_shift     = 1'b0;
        w_mode      = 1'b0;
        w_done      = 1'b0;
        w_x         = {DW{1'b0}};

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_cnt_load = 1'b1;
                    if (w_load_sat != '0)
                        w_state_nxt = ST_LOAD;
                    else if (bus.rot_len != '0)
                        w_state_nxt = ST_ROTATE;
                    else
                        w_state_nxt = ST_DONE;
                end
            end
            ST_LOAD: begin
                w_in_ready = 1'b1;
                w_x        = bus.in_data;
                if (bus.in_valid) begin
                    w_shift  = 1'b1;
                    w_ld_dec = 1'b1;
                    // A zero count here can only follow a glitch; exit rather than hang.
                    if (w_ld_last || (w_ld_value == '0))
                        w_state_nxt = (w_rot_value != '0) ? ST_ROTATE : ST_DONE;
                end
            end
            ST_ROTATE: begin
                w_shift   = 1'b1;
                w_mode    = 1'b1;
                w_rot_dec = 1'b1;
                if (w_rot_last || (w_rot_value == '0))
                    w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_abort) begin
            w_in_ready  = 1'b0;
            w_shift     = 1'b0;
            w_done      = 1'b0;
            w_ld_dec    = 1'b0;
            w_rot_dec   = 1'b0;
            w_cnt_clr   = 1'b1;
            w_state_nxt = ST_IDLE;
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.rc_x     = w_x;
    assign bus.rc_shift = w_shift;
    assign bus.rc_mode  = w_mode;
    assign bus.done     = w_done;
    assign bus.busy     = (r_state != ST_IDLE);

endmodule

`default_nettype wire
